// File: rtl/mem_bus_master.sv
// Single-outstanding load/store initiator for a word-addressed 32-bit RAM port.
// Requests are handled one at a time. A stalled command is held unchanged until the slave takes it.
module mem_bus_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = lane[0];
      2'b10:   req_bad = (lane != 2'b00);
      default: req_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_be = 4'b0001 << lane;
      2'b01:   lane_be = 4'b0011 << lane;
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  // Mask before shifting so lanes outside the byte enables are always zero.
  function automatic logic [31:0] lane_wdata(input logic [31:0] wdata, input logic [1:0] size,
                                             input logic [1:0] lane);
    logic [31:0] masked;
    case (size)
      2'b00:   masked = {24'h0, wdata[7:0]};
      2'b01:   masked = {16'h0, wdata[15:0]};
      default: masked = wdata;
    endcase
    lane_wdata = masked << {lane, 3'b000};
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
    logic [31:0] s;
    s = word >> {lane, 3'b000};
    case (size)
      2'b00:   load_extract = sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
      2'b01:   load_extract = sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      default: load_extract = s;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      lane_q  <= 2'b00;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    lane_d  = lane_q;
    err_d   = err_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          lane_d  = req_addr[1:0];
          err_d   = req_bad(req_size, req_addr[1:0]);
          addr_d  = {req_addr[31:2], 2'b00};
          be_d    = lane_be(req_size, req_addr[1:0]);
          wdata_d = lane_wdata(req_wdata, req_size, req_addr[1:0]);
          if (req_bad(req_size, req_addr[1:0])) begin
            rdata_d = 32'h0;
            state_d = S_RESP;
          end else begin
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (!mem_waitrequest) begin
          if (wr_q) begin
            rdata_d = 32'h0;
            state_d = S_RESP;
          end else begin
            cnt_d   = LAT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The count starts at the latency, so the sample lands exactly READ_LATENCY edges after accept.
        if (cnt_q == 3'd1) begin
          rdata_d = load_extract(mem_readdata, size_q, sgn_q, lane_q);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = (state_q == S_RESP);
  assign resp_error     = (state_q == S_RESP) && err_q;
  assign resp_rdata     = rdata_q;
  assign mem_read       = (state_q == S_CMD) && !wr_q;
  assign mem_write      = (state_q == S_CMD) && wr_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized and directed bench for mem_bus_master with a READ_LATENCY=2 slave model.
module tb_mem_bus_master;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;
  logic [3:0]  mem_byteenable;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_bus_master #(.READ_LATENCY(RL)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_err(input int size, input int lane);
    if (size == 3) return 1'b1;
    if (size == 1) return (lane % 2) != 0;
    if (size == 2) return lane != 0;
    return 1'b0;
  endfunction

  function automatic int m_nbytes(input int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_be(input int size, input int lane);
    return 32'(((1 << m_nbytes(size)) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] wdata, input int size, input int lane);
    longint unsigned v;
    v = longint'(wdata) % (64'd1 << (8 * m_nbytes(size)));
    return 32'(v << (8 * lane));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input int size, input bit sgn,
                                         input int lane);
    longint unsigned v, lim;
    v = longint'(word) / (64'd1 << (8 * lane));
    lim = 64'd1 << (8 * m_nbytes(size));
    v = v % lim;
    if (sgn && size < 2 && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata, input int stalls,
                        input logic [31:0] word);
    bit err, got;
    int lat, exp_lat;
    logic [31:0] exp_rd;
    err = m_err(int'(size), int'(addr % 4));
    exp_rd = (wr || err) ? 32'h0 : m_load(word, int'(size), sgn, int'(addr % 4));
    exp_lat = err ? 1 : (wr ? 2 + stalls : 2 + RL + stalls);
    chk("ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = $urandom;
    lat = 1;
    if (!err) begin
      for (int i = 0; i <= stalls; i++) begin
        mem_waitrequest = (i < stalls);
        chk("cmd_read", 32'(mem_read), 32'(!wr));
        chk("cmd_write", 32'(mem_write), 32'(wr));
        chk("cmd_addr", mem_address, addr - (addr % 4));
        chk("cmd_be", 32'(mem_byteenable), m_be(int'(size), int'(addr % 4)));
        if (wr) chk("cmd_wdata", mem_writedata, m_wd(wdata, int'(size), int'(addr % 4)));
        chk("cmd_no_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1; lat++;
      end
      mem_waitrequest = 1'b1;
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      mem_readdata = (!wr && !err && c + 1 == RL) ? word : $urandom;
      if (resp_valid) got = 1'b1;
      else begin
        chk("bus_idle", 32'({mem_read, mem_write}), 32'd0);
        @(posedge clk); #1; lat++;
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_error", 32'(resp_error), 32'(err));
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_bus_idle", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk); #1;
    mem_waitrequest = 1'b0;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("rdata_hold", resp_rdata, exp_rd);
    chk("ready_after", 32'(req_ready), 32'd1);
    last_rdata = exp_rd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_signed = 1'b0; req_wdata = 32'h0; mem_waitrequest = 1'b0; mem_readdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_bus", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_be", 32'(mem_byteenable), 32'h0);
    chk("rst_wdata", mem_writedata, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, 32'h0);
    do_txn(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, 32'h80112233);
    chk("byte_signed_val", last_rdata, 32'hFFFFFF80);
    do_txn(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, 32'h80112233);
    chk("byte_unsigned_val", last_rdata, 32'h00000080);
    do_txn(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000ABCD, 0, 32'h0);
    do_txn(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 0, 32'hABCD0000);
    chk("half_unsigned_val", last_rdata, 32'h0000ABCD);
    do_txn(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 3, 32'h12345678);
    do_txn(1'b0, 32'h06, 2'b10, 1'b0, 32'h0, 0, 32'h0);
    do_txn(1'b1, 32'h08, 2'b11, 1'b0, 32'hFFFFFFFF, 0, 32'h0);

    // Abort a load during its read-latency wait.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_wait", 32'({mem_read, mem_write, resp_valid}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_bus", 32'({mem_read, mem_write}), 32'd0);
    for (int c = 0; c < 6; c++) begin
      mem_readdata = $urandom;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_rdata", resp_rdata, 32'h0);
    do_txn(1'b1, 32'h44, 2'b10, 1'b0, 32'hCAFEF00D, 1, 32'h0);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % 4) + 32'(($urandom_range(0, 1)) * 2 * $urandom_range(0, 1));
      do_txn(1'($urandom), a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
             int'($urandom_range(0, 3)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Memory-bus initiator that turns single load/store requests from the CPU datapath into word-addressed transactions on the 32-bit RAM port (address/read/write/writedata/readdata), with a `waitrequest` stall and a fixed read latency. It generates byte enables and lane-shifted write data for byte, half and word accesses. It extracts, sign- or zero-extends and right-aligns load data. It sits between the core's load/store unit and the data RAM, one outstanding transaction at a time.

## Interface
- `READ_LATENCY`, 1, cycles from the edge at which a read command is accepted to the edge at which `mem_readdata` is sampled; legal values 1–4.

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: CPU request strobe.
- `req_ready` out 1: high only in IDLE; a request is taken on an edge with `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load result (ignored for word and for stores).
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and errors; held until next response.
- `resp_error` out 1: valid with `resp_valid`; misaligned or illegal size.
- `mem_address` out 32: `{req_addr[31:2], 2'b00}`.
- `mem_read`, `mem_write` out 1: bus command, never both high.
- `mem_byteenable` out 4: bit k enables bits [8k+7:8k].
- `mem_writedata` out 32: store data shifted to its lanes.
- `mem_waitrequest` in 1: slave stall; command is held while high.
- `mem_readdata` in 32: read data from the slave.

## Operation
- States: IDLE, CMD, WAIT, RESP.
- IDLE: `req_ready`=1. On handshake, latch all request fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 11: go to RESP with error set; no bus activity.
  - Otherwise go to CMD.
- CMD: drive `mem_read` or `mem_write` with constant address, byteenable and writedata. The command is accepted on the first edge with `mem_waitrequest`=0.
  - Write accepted: go to RESP.
  - Read accepted: go to WAIT with counter = READ_LATENCY.
- WAIT: no command asserted. Decrement the counter each edge. On the edge where the counter reaches its last cycle, sample `mem_readdata` and go to RESP. `mem_waitrequest` is ignored in WAIT.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Lane mapping is little-endian, lane = addr[1:0].
  - Byte: byteenable = 1<<lane; data at [8·lane+7:8·lane].
  - Half: byteenable = 0011 (lane 0) or 1100 (lane 2).
  - Word: byteenable = 1111.
- Store writedata: `req_wdata` shifted left by 8·lane. Bytes not enabled must be 0.
- Load: shift the sampled word right by 8·lane, mask to size, then sign-extend from bit 7/15 if `req_signed`, else zero-extend.
- Requests presented outside IDLE are ignored (`req_ready`=0).

## Timing
- Reset values:
  - state IDLE, `req_ready`=1.
  - `resp_valid`, `resp_error`, `mem_read`, `mem_write` = 0.
  - `mem_address`, `mem_byteenable`, `mem_writedata`, `resp_rdata` = 0.
- All outputs are registered or decoded from state only; no combinational path from `req_*` or `mem_*` inputs to outputs.
- Store, no stall: handshake edge E0, CMD during cycle after E0, accept E1, `resp_valid` in cycle after E1.
- Load, no stall: accept E1, sample at E1+READ_LATENCY, `resp_valid` the following cycle. Total is READ_LATENCY+2 cycles from handshake to the `resp_valid` cycle.
- Each stall cycle (`mem_waitrequest`=1 in CMD) adds exactly one cycle; the command is not dropped or changed.
- Error response: `resp_valid` in the cycle after E0; `mem_read`/`mem_write` never assert.
- Back-to-back: the next handshake is possible in the IDLE cycle following RESP. Maximum throughput is one transaction per 3 cycles (store).
- Reset mid-operation, in any state:
  - Next cycle is IDLE and `mem_read`/`mem_write`=0.
  - No `resp_valid` is produced for the aborted request.
  - A late `mem_readdata` for the aborted read is ignored.

## Test plan
- Word store addr 0x0000_0010, wdata 0xDEADBEEF → one-cycle `mem_write`, address 0x10, byteenable 1111, writedata 0xDEADBEEF. `resp_valid` 2 cycles after handshake, `resp_error`=0.
- Byte load signed addr 0x13, RAM word 0x80112233 (READ_LATENCY=1) → byteenable 1000, `resp_rdata`=0xFFFFFF80. Unsigned repeat gives 0x00000080.
- Half store addr 0x22, wdata 0x0000ABCD → byteenable 1100, writedata 0xABCD0000. Follow with half unsigned load of the same address on a RAM returning 0xABCD0000 → `resp_rdata`=0x0000ABCD.
- `mem_waitrequest` high 3 cycles on a word load (READ_LATENCY=2) → command signals stable for 4 cycles, `resp_valid` exactly 3 cycles later than the no-stall case, correct data.
- Word load at 0x06 and size 11 request → `resp_valid` and `resp_error`=1 in the next cycle, `resp_rdata`=0, no bus command.
- `reset` asserted during WAIT of a load → IDLE next cycle, no `resp_valid`. A following store completes normally.
